// File: rtl/spi_burst_pkg.sv
// Shared types and default sizing for the SPI burst sequencer.
// Optional feature macro: SPI_BURST_AUTO_TRIG_EN (see spi_burst_ctrl).
package spi_burst_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      STORE,
      DONE
   } state_t;

   localparam int unsigned DefaultDepth      = 32;
   localparam int unsigned DefaultDataW      = 8;
   localparam int unsigned DefaultTimeoutCyc = 1024;
   localparam int unsigned DefaultPeriodCyc  = 100000;

   // Final transaction address, limited to the last register of the bank.
   function automatic int unsigned clamp_n(input int unsigned n, input int unsigned max_n);
      return (n > max_n) ? max_n : n;
   endfunction

endpackage

// File: rtl/spi_burst_timer.sv
// Down-counter loaded with CYCLES-1 on clear, decrementing while enabled;
// expired is high while the count sits at zero.
module spi_burst_timer #(
   parameter int unsigned CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] Load = W'(CYCLES - 1);
   localparam logic [W-1:0] One  = W'(1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q <= Load;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - One;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer: runs n_eff+1 SPI transactions and writes each received word to the bank.
// Define SPI_BURST_AUTO_TRIG_EN to add a periodic internal start request.
module spi_burst_ctrl
   import spi_burst_pkg::*;
#(
   parameter int unsigned DEPTH       = DefaultDepth,
   parameter int unsigned DATA_W      = DefaultDataW,
`ifdef SPI_BURST_AUTO_TRIG_EN
   parameter int unsigned PERIOD_CYC  = DefaultPeriodCyc,
`endif
   parameter int unsigned TIMEOUT_CYC = DefaultTimeoutCyc,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [8:0]        n_i,
   output logic              spi_start_o,
   input  logic              spi_done_i,
   input  logic [DATA_W-1:0] spi_rx_i,
   output logic              reg_we_o,
   output logic [AW-1:0]     reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic [AW:0]       count_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [AW:0] CountOne = (AW+1)'(1);

   state_t            state_q, state_d;
   logic [AW-1:0]     n_eff_q, n_eff_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;

   logic start_req;
   logic timer_clear;
   logic timer_en;
   logic timeout;

`ifdef SPI_BURST_AUTO_TRIG_EN
   logic period_tick;

   // Reloads itself on expiry; a tick outside IDLE is simply lost.
   spi_burst_timer #(
      .CYCLES(PERIOD_CYC)
   ) u_period (
      .clk    (clk_i),
      .reset  (reset_i),
      .clear  (period_tick),
      .en     (1'b1),
      .expired(period_tick)
   );

   assign start_req = start_i | period_tick;
`else
   assign start_req = start_i;
`endif

   assign timer_clear = (state_q == START);
   assign timer_en    = (state_q == WAIT);

   spi_burst_timer #(
      .CYCLES(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk_i),
      .reset  (reset_i),
      .clear  (timer_clear),
      .en     (timer_en),
      .expired(timeout)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         n_eff_q <= '0;
         count_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_eff_q <= n_eff_d;
         count_q <= count_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      n_eff_d     = n_eff_q;
      count_d     = count_q;
      data_d      = data_q;
      err_d       = err_q;
      spi_start_o = 1'b0;
      reg_we_o    = 1'b0;
      reg_addr_o  = '0;
      reg_wdata_o = '0;
      done_o      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_req) begin
               n_eff_d = AW'(clamp_n(32'(n_i), DEPTH - 1));
               count_d = '0;
               err_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            spi_start_o = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            // A completion arriving on the timeout cycle still counts.
            if (spi_done_i) begin
               data_d  = spi_rx_i;
               state_d = STORE;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         STORE: begin
            reg_we_o    = 1'b1;
            reg_addr_o  = count_q[AW-1:0];
            reg_wdata_o = data_q;
            count_d     = count_q + CountOne;
            state_d     = (count_q[AW-1:0] == n_eff_q) ? DONE : START;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign count_o = count_q;
   assign busy_o  = (state_q != IDLE);
   assign err_o   = err_q;

endmodule
